dynamic_routing_mul_arbiter: RTL and testbench

//  Shares one unsigned 14x12 multiplier between N_REQ requesters in the digit-caps

---
 rtl/dynamic_routing_pkg.sv | 30 +++
 rtl/dynamic_routing_shared_mul.sv | 13 +
 rtl/dynamic_routing_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_dynamic_routing_mul_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dynamic_routing_pkg.sv
// Shared constants and the round-robin selection helper for the digit-caps
// dynamic-routing multiplier arbiter.
package dynamic_routing_pkg;

    localparam int A_W     = 14;
    localparam int B_W     = 12;
    localparam int P_W     = A_W + B_W;
    localparam int MAX_REQ = 8;

    // Returns a one-hot vector for the first set bit of valid, searching from
    // ptr upward and wrapping at nReq-1 back to 0. Zero when nothing is valid.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int                 ptr,
                                                   input int                 nReq);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [2:0]         sel;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            sel = 3'((ptr + k) % nReq);
            if (!found && (k < nReq) && valid[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/dynamic_routing_shared_mul.sv
// Combinational full-precision unsigned multiplier shared by all requesters.
module dynamic_routing_shared_mul
    import dynamic_routing_pkg::*;
(
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [P_W-1:0] prod_o
);

    // Both operands are zero-extended to the product width so nothing is truncated.
    assign prod_o = P_W'(a_i) * P_W'(b_i);

endmodule

// File: rtl/dynamic_routing_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier through a two-stage
// registered pipe; products leave on a single tagged response port.
module dynamic_routing_mul_arbiter
    import dynamic_routing_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
)
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [P_W-1:0]     rsp_prod
);

    logic               s1Valid_q, s1Valid_d;
    logic [A_W-1:0]     s1A_q, s1A_d;
    logic [B_W-1:0]     s1B_q, s1B_d;
    logic [ID_W-1:0]    s1Id_q, s1Id_d;
    logic [ID_W-1:0]    rrPtr_q, rrPtr_d;
    logic               rspValid_q, rspValid_d;
    logic [P_W-1:0]     rspProd_q, rspProd_d;
    logic [ID_W-1:0]    rspId_q, rspId_d;

    logic               s2Adv;
    logic               s1Adv;
    logic [MAX_REQ-1:0] validPad;
    logic [MAX_REQ-1:0] pickAll;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grantIdx;
    logic [A_W-1:0]     selA;
    logic [B_W-1:0]     selB;
    logic [P_W-1:0]     mulProd;

    assign s2Adv = !rspValid_q || rsp_ready;
    assign s1Adv = !s1Valid_q || s2Adv;

    // Pick the next requester round-robin and mux its operands; no grant while
    // S1 cannot move or while reset is held.
    always_comb begin
        validPad             = '0;
        validPad[N_REQ-1:0]  = req_valid;
        pickAll              = rr_pick(validPad, int'(rrPtr_q), N_REQ);
        grant                = (s1Adv && !ap_rst) ? pickAll[N_REQ-1:0] : '0;
        grantIdx             = '0;
        selA                 = '0;
        selB                 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grantIdx = ID_W'(i);
                selA     = req_a[i*A_W +: A_W];
                selB     = req_b[i*B_W +: B_W];
            end
        end
    end

    assign req_ready = grant;

    dynamic_routing_shared_mul uMul (
        .a_i    (s1A_q),
        .b_i    (s1B_q),
        .prod_o (mulProd)
    );

    // Next state for both pipe stages and the round-robin pointer.
    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1A_d      = s1A_q;
        s1B_d      = s1B_q;
        s1Id_d     = s1Id_q;
        rrPtr_d    = rrPtr_q;
        rspValid_d = rspValid_q;
        rspProd_d  = rspProd_q;
        rspId_d    = rspId_q;
        if (s1Adv) begin
            if (|grant) begin
                s1Valid_d = 1'b1;
                s1A_d     = selA;
                s1B_d     = selB;
                s1Id_d    = grantIdx;
                rrPtr_d   = (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
            end else begin
                s1Valid_d = 1'b0;
            end
        end
        if (s2Adv) begin
            rspValid_d = s1Valid_q;
            if (s1Valid_q) begin
                rspProd_d = mulProd;
                rspId_d   = s1Id_q;
            end
        end
    end

    // Pipe registers; reset drops anything in flight.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1Valid_q  <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s1Id_q     <= '0;
            rrPtr_q    <= '0;
            rspValid_q <= 1'b0;
            rspProd_q  <= '0;
            rspId_q    <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1A_q      <= s1A_d;
            s1B_q      <= s1B_d;
            s1Id_q     <= s1Id_d;
            rrPtr_q    <= rrPtr_d;
            rspValid_q <= rspValid_d;
            rspProd_q  <= rspProd_d;
            rspId_q    <= rspId_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_prod  = rspProd_q;
    assign rsp_id    = rspId_q;

endmodule

// File: tb/tb_dynamic_routing_mul_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic checked against a
// queue-based model of in-flight products.
module tb_dynamic_routing_mul_arbiter;
    import dynamic_routing_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*A_W-1:0]   req_a;
    logic [N*B_W-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [P_W-1:0]     rsp_prod;

    dynamic_routing_mul_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
    );

    // Free-running clock.
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int     id;
        longint prod;
        int     age;
    } item_t;

    item_t          pipeQ[$];
    int             outId[$];
    longint         outProd[$];
    int             rrPtrModel;
    int             testCount;
    int             failCount;
    int             xferCount;
    logic [N-1:0]   vldBits;
    logic [A_W-1:0] opA[N];
    logic [B_W-1:0] opB[N];
    logic           rspReadyDrv;
    logic           holdValid;

    task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        req_valid = vldBits;
        for (int i = 0; i < N; i++) begin
            req_a[i*A_W +: A_W] = opA[i];
            req_b[i*B_W +: B_W] = opB[i];
        end
        rsp_ready = rspReadyDrv;
    endtask

    // Compares the DUT against the model for the current cycle; returns the
    // expected grant index (-1 for none) and whether the head is being accepted.
    task automatic checkOutput(output int g, output logic popping);
        logic [N-1:0] expReady;
        logic         visible;
        g = -1;
        if (!ap_rst && (pipeQ.size() < 2 || rspReadyDrv)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && vldBits[(rrPtrModel + k) % N]) g = (rrPtrModel + k) % N;
            end
        end
        expReady = (g >= 0) ? N'(1 << g) : '0;
        checkEq("req_ready", 64'(req_ready), 64'(expReady));
        visible = (pipeQ.size() > 0) && (pipeQ[0].age >= 2);
        checkEq("rsp_valid", 64'(rsp_valid), 64'(visible));
        if (visible) begin
            checkEq("rsp_id", 64'(rsp_id), 64'(pipeQ[0].id));
            checkEq("rsp_prod", 64'(rsp_prod), 64'(pipeQ[0].prod));
        end
        popping = visible && rspReadyDrv;
    endtask

    task automatic tick();
        int   g;
        logic popping;
        item_t it;
        applyStimulus();
        #1;
        checkOutput(g, popping);
        @(posedge ap_clk);
        if (ap_rst) begin
            pipeQ.delete();
            rrPtrModel = 0;
        end else begin
            if (popping) begin
                outId.push_back(pipeQ[0].id);
                outProd.push_back(pipeQ[0].prod);
                void'(pipeQ.pop_front());
            end
            foreach (pipeQ[j]) pipeQ[j].age++;
            if (g >= 0) begin
                it.id   = g;
                it.prod = longint'(opA[g]) * longint'(opB[g]);
                it.age  = 1;
                pipeQ.push_back(it);
                rrPtrModel = (g + 1) % N;
                xferCount++;
                if (holdValid) begin
                    opA[g] = A_W'($urandom);
                    opB[g] = B_W'($urandom);
                end else begin
                    vldBits[g] = 1'b0;
                end
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic doReset();
        ap_rst      = 1'b1;
        vldBits     = '0;
        rspReadyDrv = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
    endtask

    task automatic drain();
        vldBits     = '0;
        rspReadyDrv = 1'b1;
        for (int c = 0; c < 20 && pipeQ.size() > 0; c++) tick();
        checkEq("drain_empty", 64'(pipeQ.size()), 64'd0);
        tick();
    endtask

    task automatic clearLog();
        outId.delete();
        outProd.delete();
    endtask

    initial begin
        longint exp3[5] = '{2, 6, 12, 20, 30};
        int     k;
        testCount   = 0;
        failCount   = 0;
        xferCount   = 0;
        rrPtrModel  = 0;
        holdValid   = 1'b0;
        vldBits     = '0;
        rspReadyDrv = 1'b1;
        ap_rst      = 1'b1;
        for (int i = 0; i < N; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        applyStimulus();
        @(negedge ap_clk);
        doReset();
        #1;
        checkEq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkEq("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkEq("reset_rsp_prod", 64'(rsp_prod), 64'd0);
        checkEq("reset_req_ready", 64'(req_ready), 64'd0);

        // Single max-value operation from requester 0.
        clearLog();
        opA[0] = 14'd16383;
        opB[0] = 12'd4095;
        vldBits = 4'b0001;
        tick();
        vldBits = '0;
        tick();
        tick();
        tick();
        checkEq("t1_count", 64'(outProd.size()), 64'd1);
        if (outProd.size() == 1) begin
            checkEq("t1_prod", 64'(outProd[0]), 64'd67088385);
            checkEq("t1_id", 64'(outId[0]), 64'd0);
        end

        // All four requesters continuously valid.
        doReset();
        clearLog();
        holdValid = 1'b1;
        for (int i = 0; i < N; i++) begin
            opA[i] = A_W'($urandom);
            opB[i] = B_W'($urandom);
        end
        vldBits = 4'b1111;
        for (int c = 0; c < 8; c++) tick();
        holdValid = 1'b0;
        drain();
        checkEq("t2_count", 64'(outId.size()), 64'd8);
        for (int i = 0; i < 8 && i < outId.size(); i++) checkEq("t2_order", 64'(outId[i]), 64'(i % 4));

        // Requester 2 streams five operations back to back.
        clearLog();
        xferCount = 0;
        k = 1;
        for (int c = 0; c < 20 && k <= 5; c++) begin
            opA[2] = A_W'(k);
            opB[2] = B_W'(k + 1);
            vldBits[2] = 1'b1;
            tick();
            if (!vldBits[2]) k++;
        end
        checkEq("t3_xfers", 64'(xferCount), 64'd5);
        drain();
        checkEq("t3_count", 64'(outProd.size()), 64'd5);
        for (int i = 0; i < 5 && i < outProd.size(); i++) checkEq("t3_prod", 64'(outProd[i]), 64'(exp3[i]));

        // Backpressure with three requesters pending.
        doReset();
        clearLog();
        xferCount = 0;
        for (int i = 0; i < 3; i++) begin
            opA[i] = A_W'($urandom);
            opB[i] = B_W'($urandom);
        end
        vldBits     = 4'b0111;
        rspReadyDrv = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        checkEq("t4_xfers", 64'(xferCount), 64'd2);
        rspReadyDrv = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        drain();
        checkEq("t4_count", 64'(outId.size()), 64'd3);
        for (int i = 0; i < 3 && i < outId.size(); i++) checkEq("t4_order", 64'(outId[i]), 64'(i));

        // Reset while both stages are occupied.
        doReset();
        clearLog();
        vldBits     = 4'b0011;
        rspReadyDrv = 1'b0;
        tick();
        tick();
        ap_rst  = 1'b1;
        vldBits = '0;
        tick();
        ap_rst      = 1'b0;
        rspReadyDrv = 1'b1;
        #1;
        checkEq("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        vldBits = 4'b1111;
        applyStimulus();
        #1;
        checkEq("t5_ptr_zero", 64'(req_ready), 64'b0001);
        tick();
        tick();
        tick();
        tick();
        drain();
        checkEq("t5_count", 64'(outId.size()), 64'd4);

        // Zero and unit operands.
        clearLog();
        opA[1] = 14'd0;     opB[1] = 12'd4095; vldBits[1] = 1'b1;
        for (int c = 0; c < 5 && vldBits[1]; c++) tick();
        opA[1] = 14'd16383; opB[1] = 12'd0;    vldBits[1] = 1'b1;
        for (int c = 0; c < 5 && vldBits[1]; c++) tick();
        opA[1] = 14'd1;     opB[1] = 12'd1;    vldBits[1] = 1'b1;
        for (int c = 0; c < 5 && vldBits[1]; c++) tick();
        drain();
        checkEq("t6_count", 64'(outProd.size()), 64'd3);
        if (outProd.size() == 3) begin
            checkEq("t6_zero_a", 64'(outProd[0]), 64'd0);
            checkEq("t6_zero_b", 64'(outProd[1]), 64'd0);
            checkEq("t6_one", 64'(outProd[2]), 64'd1);
        end

        // Random traffic with random backpressure.
        clearLog();
        xferCount = 0;
        for (int c = 0; c < 1500 && xferCount < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vldBits[i] && $urandom_range(0, 2) == 0) begin
                    vldBits[i] = 1'b1;
                    case ($urandom_range(0, 7))
                        0:       begin opA[i] = '1; opB[i] = '1; end
                        1:       begin opA[i] = '0; opB[i] = B_W'($urandom); end
                        default: begin opA[i] = A_W'($urandom); opB[i] = B_W'($urandom); end
                    endcase
                end
            end
            rspReadyDrv = ($urandom_range(0, 3) != 0);
            tick();
        end
        checkEq("rand_xfers", 64'(xferCount >= 1000), 64'd1);
        drain();
        checkEq("rand_out_count", 64'(outProd.size()), 64'(xferCount));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
